// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: opcode encodings and the multicycle adder FSM states.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } addsub_state_t;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full_adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_sub_multicycle.sv
// Multicycle two's-complement adder/subtractor: one shared CHUNK-bit ripple slice walks
// the operands LSB-first, carrying between cycles, and produces NZCV on the last slice.
module adder_sub_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

  addsub_state_t r_state;
  addsub_state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic             r_n, r_z, r_c, r_v;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_result_next;

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a        (r_a[CHUNK-1:0]),
    .b        (r_b[CHUNK-1:0]),
    .cin      (r_carry),
    .sum      (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // Result fills from the top: after NCHUNK shifts slice 0 has landed in the LSBs.
  assign w_last        = (r_k == K_LAST);
  assign w_result_next = (r_result >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_BUSY;
      ST_BUSY: if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
            r_a     <= a;
            r_b     <= (op_sub == ALU_OP_SUB) ? ~b : b;
            r_carry <= op_sub;
            r_k     <= '0;
          end
        end
        ST_BUSY: begin
          r_a      <= r_a >> CHUNK;
          r_b      <= r_b >> CHUNK;
          r_result <= w_result_next;
          r_carry  <= w_cout;
          r_k      <= r_k + 1'b1;
          if (w_last) begin
            r_n <= w_sum[CHUNK-1];
            r_z <= (w_result_next == '0);
            r_c <= w_cout;
            r_v <= w_cmsb ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign flag_n = r_n;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule

// File: tb/tb_adder_sub_multicycle.sv
// Directed self-checking bench for adder_sub_multicycle at 32/8, 32/32 and 16/4.
module tb_adder_sub_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv [3];
  logic        orr[3];
  logic        sb [3];
  logic [31:0] opa[3];
  logic [31:0] opb[3];
  logic        ir [3];
  logic        ov [3];
  logic        fn [3];
  logic        fz [3];
  logic        fc [3];
  logic        fv [3];
  logic [31:0] res0, res1;
  logic [15:0] res2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_sub_multicycle #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op_sub(sb[0]),
    .a(opa[0]), .b(opb[0]), .out_valid(ov[0]), .out_ready(orr[0]), .result(res0),
    .flag_n(fn[0]), .flag_z(fz[0]), .flag_c(fc[0]), .flag_v(fv[0]));

  adder_sub_multicycle #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op_sub(sb[1]),
    .a(opa[1]), .b(opb[1]), .out_valid(ov[1]), .out_ready(orr[1]), .result(res1),
    .flag_n(fn[1]), .flag_z(fz[1]), .flag_c(fc[1]), .flag_v(fv[1]));

  adder_sub_multicycle #(.WIDTH(16), .CHUNK(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op_sub(sb[2]),
    .a(opa[2][15:0]), .b(opb[2][15:0]), .out_valid(ov[2]), .out_ready(orr[2]), .result(res2),
    .flag_n(fn[2]), .flag_z(fz[2]), .flag_c(fc[2]), .flag_v(fv[2]));

  function automatic logic [31:0] get_res(input int i);
    case (i)
      0:       return res0;
      1:       return res1;
      default: return {16'h0, res2};
    endcase
  endfunction

  function automatic logic [3:0] get_nzcv(input int i);
    return {fn[i], fz[i], fc[i], fv[i]};
  endfunction

  // Issue one op, scramble inputs after accept, wait (bounded) for out_valid, then release.
  task automatic run_op(input int i, input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    @(posedge clk); #1;
    iv[i] = 1'b1; sb[i] = s; opa[i] = x; opb[i] = y; orr[i] = 1'b0;
    @(posedge clk); #1;
    iv[i] = 1'b0; sb[i] = ~s; opa[i] = ~x; opb[i] = ~y;
    lat = 0;
    while (!ov[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = get_res(i);
    f = get_nzcv(i);
    orr[i] = 1'b1;
    @(posedge clk); #1;
    orr[i] = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", ir[0]); end
    n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", ov[0]); end
    n_checks++; if (res0 !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", res0); end
    n_checks++; if (get_nzcv(0) !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", get_nzcv(0)); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL post_reset_handshake got ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]); end
  endtask

  task automatic test_arith;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [31:0] vr [6];
    logic [3:0]  vf [6];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vs[0] = 1'b0; vr[0] = 32'hFFFF_FFFE; vf[0] = 4'b1010;
    va[1] = 32'h0000_0001; vb[1] = 32'hFFFF_FFFF; vs[1] = 1'b0; vr[1] = 32'h0000_0000; vf[1] = 4'b0110;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = 1'b0; vr[2] = 32'h8000_0000; vf[2] = 4'b1001;
    va[3] = 32'h0000_0000; vb[3] = 32'h0000_0001; vs[3] = 1'b1; vr[3] = 32'hFFFF_FFFF; vf[3] = 4'b1000;
    va[4] = 32'h0000_0000; vb[4] = 32'h8000_0000; vs[4] = 1'b1; vr[4] = 32'h8000_0000; vf[4] = 4'b1001;
    va[5] = 32'h0000_0005; vb[5] = 32'h0000_0003; vs[5] = 1'b1; vr[5] = 32'h0000_0002; vf[5] = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      run_op(0, vs[k], va[k], vb[k], r, f, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL arith%0d_latency got %0d exp 4", k, lat); end
      n_checks++; if (r !== vr[k]) begin n_fail++; $display("FAIL arith%0d_result got %h exp %h", k, r, vr[k]); end
      n_checks++; if (f !== vf[k]) begin n_fail++; $display("FAIL arith%0d_nzcv got %b exp %b", k, f, vf[k]); end
    end
  endtask

  task automatic test_hold;
    int lat;
    int seen;
    @(posedge clk); #1;
    iv[0] = 1'b1; sb[0] = 1'b0; opa[0] = 32'hAAAA_AAAA; opb[0] = 32'h5555_5555; orr[0] = 1'b0;
    @(posedge clk); #1;
    opa[0] = 32'h0000_0001; opb[0] = 32'h0000_0001;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL hold_latency got %0d exp 4", lat); end
    iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || res0 !== 32'hFFFF_FFFF)
        begin n_fail++; $display("FAIL hold_stable%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=ffffffff", k, ov[0], ir[0], res0); end
      @(posedge clk); #1;
    end
    n_checks++; if (get_nzcv(0) !== 4'b1000) begin n_fail++; $display("FAIL hold_nzcv got %b exp 1000", get_nzcv(0)); end
    iv[0] = 1'b0; orr[0] = 1'b1;
    @(posedge clk); #1;
    orr[0] = 1'b0;
    n_checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL hold_release got ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (ov[0]) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL hold_no_phantom got %0d out_valid cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    orr[0] = 1'b1; iv[0] = 1'b1; sb[0] = 1'b0; opa[0] = 32'h0000_0010; opb[0] = 32'h0000_0020;
    lat = 0;
    while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (res0 !== 32'h0000_0030 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_first got ov=%b res=%h exp ov=1 res=00000030", ov[0], res0); end
    sb[0] = 1'b1; opa[0] = 32'h0000_0010; opb[0] = 32'h0000_0020;
    @(posedge clk); #1;
    n_checks++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_single_pulse got ov=%b ir=%b exp ov=0 ir=1", ov[0], ir[0]); end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (res0 !== 32'hFFFF_FFF0 || get_nzcv(0) !== 4'b1000) begin n_fail++; $display("FAIL b2b_second got res=%h nzcv=%b exp res=fffffff0 nzcv=1000", res0, get_nzcv(0)); end
    @(posedge clk); #1;
    orr[0] = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    int seen;
    @(posedge clk); #1;
    iv[0] = 1'b1; sb[0] = 1'b0; opa[0] = 32'h1234_5678; opb[0] = 32'h1111_1111; orr[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (res0 !== 32'h0 || get_nzcv(0) !== 4'b0000 || ov[0] !== 1'b0 || ir[0] !== 1'b1)
      begin n_fail++; $display("FAIL midreset_outputs got res=%h nzcv=%b ov=%b ir=%b exp 0/0000/0/1", res0, get_nzcv(0), ov[0], ir[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (ov[0]) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_valid got %0d exp 0", seen); end
    n_checks++; if (ir[0] !== 1'b1 || res0 !== 32'h0) begin n_fail++; $display("FAIL midreset_after got ir=%b res=%h exp ir=1 res=0", ir[0], res0); end
    orr[0] = 1'b0;
  endtask

  task automatic test_other_configs;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    run_op(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL c32_lat got %0d exp 1", lat); end
    n_checks++; if (r !== 32'hFFFF_FFFE || f !== 4'b1010) begin n_fail++; $display("FAIL c32_add1 got %h/%b exp fffffffe/1010", r, f); end
    run_op(1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, r, f, lat);
    n_checks++; if (r !== 32'h0 || f !== 4'b0110) begin n_fail++; $display("FAIL c32_add2 got %h/%b exp 00000000/0110", r, f); end
    run_op(2, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, r, f, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL w16_lat got %0d exp 4", lat); end
    n_checks++; if (r !== 32'h0000_FFFE || f !== 4'b1010) begin n_fail++; $display("FAIL w16_add1 got %h/%b exp 0000fffe/1010", r, f); end
    run_op(2, 1'b0, 32'h0000_0001, 32'h0000_FFFF, r, f, lat);
    n_checks++; if (r !== 32'h0 || f !== 4'b0110) begin n_fail++; $display("FAIL w16_add2 got %h/%b exp 00000000/0110", r, f); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b0; sb[i] = 1'b0; opa[i] = '0; opb[i] = '0;
    end
    test_reset();
    test_arith();
    test_hold();
    test_back_to_back();
    test_reset_mid_busy();
    test_other_configs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
